jstk2_spi_responder: RTL and testbench
======================================

# jstk2_spi_responder

SPI responder that emulates the Digilent PmodJSTK2 on the slave side of the joystick link. It samples `x_val`, `y_val` and `btn` at the start of each frame and shifts a 5-byte packet out on MISO under master-supplied SS/SCLK. It is used as a bench/board-level stand-in for the physical joystick, so the SPI master and the servo steering path can be exercised without hardware.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flip-flop stages on the SS and SCLK synchronizers (≥2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `SS`  in  1  slave select from master, active low, asynchronous to `clk`
- `SCLK`  in  1  SPI clock from master, mode 0, asynchronous to `clk`
- `x_val`  in  10  joystick X position, 0..1023
- `y_val`  in  10  joystick Y position, 0..1023
- `btn`  in  2  bit0 = stick button, bit1 = trigger
- `MISO`  out  1  serial data to master, MSB first
- `frame_done`  out  1  one-cycle pulse when SS deasserts after a complete 40-bit frame

## Operation
- Frame layout: 40 bits, MSB first. Byte order: `x_val[7:0]`, `{6'b0,x_val[9:8]}`, `y_val[7:0]`, `{6'b0,y_val[9:8]}`, `{6'b0,btn}`.
- SS and SCLK each pass through a `SYNC_STAGES` synchronizer, followed by an edge detector.
- FSM states: IDLE, SHIFT, PAD, LOCKOUT.
  - IDLE: `MISO`=0. On an SS falling edge, load the 40-bit snapshot into the shift register, put bit 39 on `MISO`, clear the bit count, and go to SHIFT.
  - SHIFT: on each SCLK falling edge, shift left and increment the count. Once the count reaches 39 and a further falling edge occurs (the 40 bits are consumed), go to PAD.
  - PAD: `MISO`=0 for any extra clocks.
  - On an SS rising edge from SHIFT or PAD, go to IDLE. `frame_done` pulses only when leaving PAD (the frame was complete).
  - LOCKOUT: entered from reset when the synchronized SS is low. Stay there with `MISO`=0 until SS is seen high, then go to IDLE. If SS is high at reset, go to IDLE directly.
- SCLK rising edges are ignored; the master samples on them. SCLK edges outside SHIFT/PAD are ignored.
- The input snapshot is taken only at SS falling. Input changes mid-frame do not affect the frame in progress.
- If SS falling and SCLK falling are detected in the same cycle, the SS edge wins: load the snapshot and do not shift.
- An SS rising edge before bit 40 aborts the frame: return to IDLE, no `frame_done`.

## Timing
- Reset values: `MISO`=0, `frame_done`=0, shift register 0, count 0, synchronizers cleared to 1 for SS and 0 for SCLK.
- SS falling to MSB valid on `MISO`: `SYNC_STAGES`+1 `clk` cycles.
- SCLK falling to next bit on `MISO`: `SYNC_STAGES`+1 `clk` cycles.
- SS rising to `frame_done` pulse: `SYNC_STAGES`+1 cycles. The pulse is exactly 1 cycle wide.
- Requirement on the master: each SCLK half-period is at least (`SYNC_STAGES`+3) `clk` periods, so the new bit is stable before the next SCLK rising edge.
- `MISO` is registered. It is never tri-stated.

## Structure
- Shared package `jstk2_pkg` holds:
  - `FRAME_BITS`=40
  - a byte-packing function from `(x,y,btn)` to the 40-bit frame
  - the state enum `jstk2_rsp_state_t`
- The package is shared with the master-side interface so both ends agree on the frame layout.
- One sub-module, `sync_edge`: a parameterized synchronizer with rise/fall pulse outputs, instantiated twice (SS, SCLK).

## Test plan
- Basic frame: `x_val`=10'h2A5, `y_val`=10'h17F, `btn`=2'b10; master clocks 40 bits with SCLK half-period 8 `clk` → bytes received A5 02 7F 01 02; one `frame_done` pulse after SS high.
- Snapshot hold: change `x_val` from 10'h000 to 10'h3FF after bit 5 → frame still carries 00 00; the next frame carries FF 03.
- Abort: SS high after 17 bits → no `frame_done`, `MISO`=0. The next full frame is correct from bit 39.
- Overclock: 48 SCLK cycles in one frame → the last 8 bits read 0x00, and `frame_done` still pulses once.
- Reset with SS low mid-frame → `MISO`=0 for the rest of that frame and all SCLK edges are ignored. After SS goes high then low, the frame is correct.
- Simultaneous edges: SS falling and SCLK falling in the same synchronized cycle → no shift occurs, and the first bit read is bit 39.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared PmodJSTK2 frame definitions used by both ends of the joystick SPI link.
package jstk2_pkg;

  localparam int FRAME_BITS = 40;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_SHIFT   = 2'd1,
    RSP_PAD     = 2'd2,
    RSP_LOCKOUT = 2'd3
  } jstk2_rsp_state_t;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [9:0] x,
                                                       input logic [9:0] y,
                                                       input logic [1:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, b};
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_sync_edge.sv
// Multi-flop synchronizer with registered-history edge detection.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2 stand-in: snapshots x/y/btn at SS fall and shifts a 40-bit frame out on MISO.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS,
  input  logic       SCLK,
  input  logic [9:0] x_val,
  input  logic [9:0] y_val,
  input  logic [1:0] btn,
  output logic       MISO,
  output logic       frame_done
);

  localparam int LW = $clog2(SYNC_STAGES + 2);
  localparam logic [LW-1:0] LOCK_N   = LW'(SYNC_STAGES);
  localparam logic [5:0]    LAST_BIT = 6'(FRAME_BITS - 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic unused_sclk;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .din(SS), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // The master samples on SCLK rising edges, so only falling edges move data.
  assign unused_sclk = sclk_lvl ^ sclk_rise;

  jstk2_rsp_state_t       state;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  snap;
  logic [5:0]             cnt;
  logic [LW-1:0]          lock_cnt;
  logic                   miso_q;

  assign snap = pack_frame(x_val, y_val, btn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RSP_LOCKOUT;
      shreg      <= '0;
      cnt        <= '0;
      lock_cnt   <= '0;
      miso_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        // Synchronizer reset value reads as "high", so wait for it to flush
        // before trusting the level; a master mid-frame keeps us parked here.
        RSP_LOCKOUT: begin
          miso_q <= 1'b0;
          if (lock_cnt != LOCK_N) lock_cnt <= lock_cnt + 1'b1;
          else if (ss_lvl)        state    <= RSP_IDLE;
        end
        RSP_IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            shreg  <= snap;
            miso_q <= snap[FRAME_BITS-1];
            cnt    <= '0;
            state  <= RSP_SHIFT;
          end
        end
        RSP_SHIFT: begin
          if (ss_rise) begin
            miso_q <= 1'b0;
            state  <= RSP_IDLE;
          end else if (sclk_fall) begin
            if (cnt == LAST_BIT) begin
              miso_q <= 1'b0;
              state  <= RSP_PAD;
            end else begin
              shreg  <= shreg << 1;
              cnt    <= cnt + 1'b1;
              miso_q <= shreg[FRAME_BITS-2];
            end
          end
        end
        RSP_PAD: begin
          miso_q <= 1'b0;
          if (ss_rise) begin
            frame_done <= 1'b1;
            state      <= RSP_IDLE;
          end
        end
        default: begin
          miso_q <= 1'b0;
          state  <= RSP_IDLE;
        end
      endcase
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench: bit-banged SPI master, received bytes checked against a scoreboard queue.
module tb_jstk2_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS;
  logic       SCLK;
  logic [9:0] x_val, y_val;
  logic [1:0] btn;
  logic       MISO;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0;
  int bitcnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_byte = '0;
  logic [7:0] exp_q[$];
  event rx_ev;

  jstk2_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK),
    .x_val(x_val), .y_val(y_val), .btn(btn),
    .MISO(MISO), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  // Scoreboard monitor: every byte the master assembles is matched in order.
  initial begin
    logic [7:0] e;
    forever begin
      @(rx_ev);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_byte: got %02h, no byte expected", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_byte !== e) begin
          miscompares++;
          $display("FAIL rx_byte: got %02h, expected %02h", rx_byte, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hp();
    repeat (8) @(negedge clk);
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4);
  endtask

  task automatic clk_bits(input int n);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1;
      rx_sh = {rx_sh[6:0], MISO};
      bitcnt++;
      if (bitcnt % 8 == 0) begin
        rx_byte = rx_sh;
        -> rx_ev;
      end
      hp();
      SCLK = 1'b0;
      hp();
    end
  endtask

  task automatic ss_low(input bit simul);
    if (simul) begin
      SCLK = 1'b1;
      hp();
    end
    SS = 1'b0;
    SCLK = 1'b0;
    bitcnt = 0;
    hp();
  endtask

  task automatic ss_high();
    SS = 1'b1;
    hp();
    hp();
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int fd_exp;
    rst = 1'b1; SS = 1'b1; SCLK = 1'b0;
    x_val = '0; y_val = '0; btn = '0;
    repeat (3) @(negedge clk);
    check("reset_miso", int'(MISO), 0);
    check("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    hp();

    // Basic frame
    x_val = 10'h2A5; y_val = 10'h17F; btn = 2'b10;
    push5(8'hA5, 8'h02, 8'h7F, 8'h01, 8'h02);
    ss_low(0); clk_bits(40); ss_high();
    fd_exp = 1;
    check("basic_frame_done", fd_cnt, fd_exp);

    // Snapshot hold
    x_val = 10'h000; y_val = 10'h155; btn = 2'b01;
    push5(8'h00, 8'h00, 8'h55, 8'h01, 8'h01);
    ss_low(0); clk_bits(5); x_val = 10'h3FF; clk_bits(35); ss_high();
    push5(8'hFF, 8'h03, 8'h55, 8'h01, 8'h01);
    ss_low(0); clk_bits(40); ss_high();
    fd_exp += 2;
    check("snapshot_frame_done", fd_cnt, fd_exp);

    // Abort after 17 bits
    x_val = 10'h2A5; y_val = 10'h17F; btn = 2'b10;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
    ss_low(0); clk_bits(17); ss_high();
    check("abort_no_frame_done", fd_cnt, fd_exp);
    check("abort_miso", int'(MISO), 0);
    x_val = 10'h1C3; y_val = 10'h2E4; btn = 2'b11;
    push5(8'hC3, 8'h01, 8'hE4, 8'h02, 8'h03);
    ss_low(0); clk_bits(40); ss_high();
    fd_exp += 1;
    check("after_abort_frame_done", fd_cnt, fd_exp);

    // Overclock: 48 SCLK cycles, trailing byte reads zero
    x_val = 10'h3FF; y_val = 10'h000; btn = 2'b00;
    push5(8'hFF, 8'h03, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(8'h00);
    ss_low(0); clk_bits(48); ss_high();
    fd_exp += 1;
    check("overclock_frame_done", fd_cnt, fd_exp);

    // Reset while SS low mid-frame: rest of frame reads zero
    x_val = 10'h0AB; y_val = 10'h3CD; btn = 2'b01;
    exp_q.push_back(8'hAB);
    ss_low(0); clk_bits(8);
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    check("midreset_miso", int'(MISO), 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    clk_bits(32); ss_high();
    check("midreset_no_frame_done", fd_cnt, fd_exp);
    push5(8'hAB, 8'h00, 8'hCD, 8'h03, 8'h01);
    ss_low(0); clk_bits(40); ss_high();
    fd_exp += 1;
    check("after_reset_frame_done", fd_cnt, fd_exp);

    // Simultaneous SS fall and SCLK fall: no shift, bit 39 first
    x_val = 10'h155; y_val = 10'h0AA; btn = 2'b10;
    push5(8'h55, 8'h01, 8'hAA, 8'h00, 8'h02);
    ss_low(1); clk_bits(40); ss_high();
    fd_exp += 1;
    check("simul_frame_done", fd_cnt, fd_exp);

    hp();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
